// File: rtl/fifo_fwft_mr.sv
// fifo_fwft_mr: first-word-fall-through FIFO, one write port broadcast to RD_NUM
// independent readers. Each pushed word is delivered once to every reader; the
// slowest reader throttles the writer through full.
// Latency: push at edge N -> word visible on every idle reader after edge N+1.
// Backpressure: push while full is dropped; pop while empty[k] is ignored.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   Reset             synchronous clear, highest priority
//   push, data_in     write strobe and word
//   full, almost_full storage cannot accept / fifo_count >= AFULL_THRESH
//   fifo_count        words in storage not yet fetched by the slowest reader
//   pop, data_out     per-reader consume strobe and output word (k-th slice)
//   empty             per-reader output word not valid
module fifo_fwft_mr #(
  parameter int DATA_WIDTH   = 4,
  parameter int ADDR_WIDTH   = 8,
  parameter int RAM_DEPTH    = 1 << ADDR_WIDTH,
  parameter int RD_NUM       = 2,
  parameter int AFULL_THRESH = RAM_DEPTH - 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         Reset,
  input  logic                         push,
  input  logic [DATA_WIDTH-1:0]        data_in,
  output logic                         full,
  output logic                         almost_full,
  output logic [ADDR_WIDTH:0]          fifo_count,
  input  logic [RD_NUM-1:0]            pop,
  output logic [RD_NUM*DATA_WIDTH-1:0] data_out,
  output logic [RD_NUM-1:0]            empty
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(RAM_DEPTH);
  localparam logic [PW-1:0] AFULL_P = PW'(AFULL_THRESH);

  logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

  logic [PW-1:0]                   wr_ptr_q, wr_ptr_d;
  logic [RD_NUM-1:0][PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [RD_NUM-1:0]               valid_q, valid_d;
  logic [RD_NUM*DATA_WIDTH-1:0]    dout_q, dout_d;
  logic [RD_NUM-1:0][PW-1:0]       diff;
  logic [RD_NUM-1:0]               int_empty;
  logic [RD_NUM-1:0]               fetch;
  logic [PW-1:0]                   count;
  logic                            wr_en;

  // Occupancy seen by each reader; the extra pointer MSB makes the modulo
  // difference unambiguous between 0 (empty) and RAM_DEPTH (full).
  always_comb begin
    full  = 1'b0;
    count = '0;
    for (int k = 0; k < RD_NUM; k++) begin
      diff[k]      = wr_ptr_q - rd_ptr_q[k];
      int_empty[k] = (rd_ptr_q[k] == wr_ptr_q);
      if (diff[k] == DEPTH_P) full = 1'b1;
      if (diff[k] > count)    count = diff[k];
    end
  end

  assign fifo_count  = count;
  assign almost_full = (count >= AFULL_P);
  assign wr_en       = push && !full && !Reset;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (Reset)      wr_ptr_d = '0;
    else if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
  end

  // Per-reader output stage: refill whenever the register is free or being
  // consumed this cycle, so a held pop streams one word per cycle.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    valid_d  = valid_q;
    dout_d   = dout_q;
    fetch    = '0;
    for (int k = 0; k < RD_NUM; k++) begin
      fetch[k] = !int_empty[k] && (!valid_q[k] || pop[k]);
      if (Reset) begin
        // Clear pointers and valid only; the output word is left as-is.
        rd_ptr_d[k] = '0;
        valid_d[k]  = 1'b0;
      end else if (fetch[k]) begin
        dout_d[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_ptr_q[k][ADDR_WIDTH-1:0]];
        rd_ptr_d[k] = rd_ptr_q[k] + 1'b1;
        valid_d[k]  = 1'b1;
      end else if (pop[k]) begin
        valid_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
      dout_q   <= dout_d;
    end
  end

  assign data_out = dout_q;
  assign empty    = ~valid_q;

endmodule
